// File: rtl/scan_return_rx_if.sv
// Head-of-FIFO frame handshake between scan_return_rx and its consumer.
interface scan_return_rx_if #(
   parameter int unsigned NUM_IOS   = 8,
   parameter int unsigned ADDR_BITS = 8
);
   logic                 o_valid;
   logic [ADDR_BITS-1:0] o_addr;
   logic [NUM_IOS-1:0]   o_data;
   logic                 i_ready;

   modport master (output o_valid, output o_addr, output o_data, input i_ready);
   modport slave  (input o_valid, input o_addr, input o_data, output i_ready);
endinterface

// File: rtl/scan_return_rx.sv
// Receives frames returned from the end of a scan chain (rtck/rtms/tdo, async to clk)
// and presents them to a consumer through a 2-entry FIFO.
module scan_return_rx #(
   parameter int unsigned NUM_IOS     = 8,
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rtck,
   input  logic             rtms,
   input  logic             tdo,
   scan_return_rx_if.master rx,
   output logic             busy,
   output logic             frame_err,
   output logic             overflow,
   input  logic             clr_ovf
);
   localparam int unsigned FRAME_BITS = ADDR_BITS + NUM_IOS;
   localparam int unsigned CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [SYNC_STAGES-1:0]  rtck_sync, rtms_sync, tdo_sync, sync_fill;
   logic                    rtck_d, armed;
   logic                    rtck_s, rtms_s, tdo_s, rise_c;
   logic [FRAME_BITS-2:0]   shreg;
   logic [FRAME_BITS-1:0]   frame_c;
   logic                    shift_c, push_c, abort_c, pop_c, drop_c;
   logic [FRAME_BITS-1:0]   head, tail, head_nxt, tail_nxt;
   logic [1:0]              count, count_nxt;

   assign rtck_s  = rtck_sync[SYNC_STAGES-1];
   assign rtms_s  = rtms_sync[SYNC_STAGES-1];
   assign tdo_s   = tdo_sync[SYNC_STAGES-1];
   // armed blocks a phantom edge when rtck is already high as the synchronizer fills after reset
   assign rise_c  = armed & rtck_s & ~rtck_d;
   assign shift_c = rise_c & ~rtms_s;
   assign frame_c = {tdo_s, shreg};
   assign pop_c   = rx.o_valid & rx.i_ready;

   assign busy      = (state == SHIFT);
   assign rx.o_addr = head[ADDR_BITS-1:0];
   assign rx.o_data = head[FRAME_BITS-1:ADDR_BITS];

   // Synchronizers and rising-edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         rtck_sync <= '0;
         rtms_sync <= '0;
         tdo_sync  <= '0;
         sync_fill <= '0;
         rtck_d    <= 1'b0;
         armed     <= 1'b0;
      end else begin
         rtck_sync <= {rtck_sync[SYNC_STAGES-2:0], rtck};
         rtms_sync <= {rtms_sync[SYNC_STAGES-2:0], rtms};
         tdo_sync  <= {tdo_sync[SYNC_STAGES-2:0], tdo};
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
         rtck_d    <= rtck_s;
         if (sync_fill[SYNC_STAGES-1] && !rtck_s) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (shift_c) shreg <= frame_c[FRAME_BITS-1:1];
      end
   end

   // Frame assembly FSM
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      push_c    = 1'b0;
      abort_c   = 1'b0;
      if (rise_c) begin
         if (state == IDLE) begin
            if (!rtms_s) begin
               cnt_nxt   = CNT_W'(1);
               state_nxt = SHIFT;
            end
         end else if (rtms_s) begin
            abort_c   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end else if (cnt == LAST_BIT) begin
            push_c    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   // Two-entry FIFO kept as head/tail so the head drives the outputs directly
   always_comb begin
      head_nxt  = head;
      tail_nxt  = tail;
      count_nxt = count;
      drop_c    = 1'b0;
      case ({push_c, pop_c})
         2'b10: begin
            if (count == 2'd0) begin
               head_nxt  = frame_c;
               count_nxt = 2'd1;
            end else if (count == 2'd1) begin
               tail_nxt  = frame_c;
               count_nxt = 2'd2;
            end else begin
               drop_c = 1'b1;
            end
         end
         2'b01: begin
            head_nxt  = tail;
            count_nxt = count - 2'd1;
         end
         2'b11: begin
            if (count == 2'd1) begin
               head_nxt = frame_c;
            end else begin
               head_nxt = tail;
               tail_nxt = frame_c;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= 2'd0;
         rx.o_valid <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         head       <= head_nxt;
         tail       <= tail_nxt;
         count      <= count_nxt;
         rx.o_valid <= (count_nxt != 2'd0);
         frame_err  <= abort_c;
         if (drop_c)       overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_scan_return_rx.sv
// Directed and randomized checks of scan_return_rx against an in-order frame scoreboard.
module tb_scan_return_rx;
   localparam int unsigned NUM_IOS     = 8;
   localparam int unsigned ADDR_BITS   = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned FRAME_BITS  = NUM_IOS + ADDR_BITS;

   logic clk = 1'b0;
   logic reset, rtck, rtms, tdo, clr_ovf;
   logic busy, frame_err, overflow;

   scan_return_rx_if #(.NUM_IOS(NUM_IOS), .ADDR_BITS(ADDR_BITS)) rx ();

   scan_return_rx #(.NUM_IOS(NUM_IOS), .ADDR_BITS(ADDR_BITS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .reset(reset), .rtck(rtck), .rtms(rtms), .tdo(tdo),
      .rx(rx), .busy(busy), .frame_err(frame_err), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int ferr_pulses = 0;
   logic ferr_prev = 1'b0;
   logic exp_ovf = 1'b0;
   logic [FRAME_BITS-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Consumer side: every accepted head frame must be the oldest expected one
   always @(negedge clk) begin
      if (reset) begin
         ferr_prev = 1'b0;
      end else begin
         if (frame_err) begin
            ferr_pulses++;
            check("frame_err_width", 32'(ferr_prev), 32'd0);
         end
         ferr_prev = frame_err;
         if (rx.o_valid && rx.i_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL unexpected_frame observed=0x%0h expected=none", {rx.o_data, rx.o_addr});
            end else begin
               logic [FRAME_BITS-1:0] f;
               f = exp_q.pop_front();
               check("frame_addr", 32'(rx.o_addr), 32'(f[ADDR_BITS-1:0]));
               check("frame_data", 32'(rx.o_data), 32'(f[FRAME_BITS-1:ADDR_BITS]));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic ms);
      @(posedge clk);
      #1 rtck = 1'b0; tdo = b; rtms = ms;
      tick(2);
      rtck = 1'b1;
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [FRAME_BITS-1:0] f);
      for (int i = 0; i < int'(FRAME_BITS); i++) send_bit(f[i], 1'b0);
   endtask

   // Reference model: FIFO holds at most two frames; a third unread one is lost
   task automatic model_frame(input logic [FRAME_BITS-1:0] f);
      if (exp_q.size() < 2) exp_q.push_back(f);
      else exp_ovf = 1'b1;
   endtask

   task automatic deliver(input logic [ADDR_BITS-1:0] a, input logic [NUM_IOS-1:0] d);
      model_frame({d, a});
      send_frame({d, a});
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      tick(2);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      tick(3);
      reset = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   initial begin
      logic [FRAME_BITS-1:0] f3;
      int ferr_before;
      reset = 1'b1; rtck = 1'b0; rtms = 1'b1; tdo = 1'b0; clr_ovf = 1'b0; rx.i_ready = 1'b0;
      tick(3);
      reset = 1'b0;
      check("rst_valid", 32'(rx.o_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_addr", 32'(rx.o_addr), 32'd0);
      check("rst_data", 32'(rx.o_data), 32'd0);
      tick(5);

      // Single frame
      rx.i_ready = 1'b1;
      deliver(8'h01, 8'hA5);
      wait_drain();
      check("single_overflow", 32'(overflow), 32'd0);
      check("single_ferr", 32'(ferr_pulses), 32'd0);

      // Overflow with a stalled consumer, then in-order drain and clear
      rx.i_ready = 1'b0;
      deliver(8'h03, 8'h11);
      deliver(8'h04, 8'h22);
      deliver(8'h05, 8'h33);
      tick(6);
      check("ovf_set", 32'(overflow), 32'(exp_ovf));
      check("ovf_valid", 32'(rx.o_valid), 32'd1);
      check("ovf_head_addr", 32'(rx.o_addr), 32'h03);
      check("ovf_head_data", 32'(rx.o_data), 32'h11);
      rx.i_ready = 1'b1;
      wait_drain();
      check("ovf_drained_valid", 32'(rx.o_valid), 32'd0);
      check("ovf_still_set", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      exp_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'(exp_ovf));

      // Abort after 9 bits
      for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b0);
      tick(3);
      check("abort_busy_before", 32'(busy), 32'd1);
      send_bit(1'b0, 1'b1);
      tick(4);
      check("abort_busy_after", 32'(busy), 32'd0);
      check("abort_ferr_count", 32'(ferr_pulses), 32'd1);
      check("abort_no_valid", 32'(rx.o_valid), 32'd0);
      deliver(8'h07, 8'h5A);
      wait_drain();

      // Final bit of a new frame coincides with a pop from a full FIFO
      rx.i_ready = 1'b0;
      deliver(8'h21, 8'h9C);
      deliver(8'h22, 8'h4E);
      tick(6);
      f3 = {8'hE7, 8'h23};
      exp_q.push_back(f3);
      for (int i = 0; i < int'(FRAME_BITS) - 1; i++) send_bit(f3[i], 1'b0);
      @(posedge clk);
      #1 rtck = 1'b0; tdo = f3[FRAME_BITS-1]; rtms = 1'b0;
      tick(2);
      rtck = 1'b1;
      tick(SYNC_STAGES);
      rx.i_ready = 1'b1;
      tick(1);
      rx.i_ready = 1'b0;
      tick(2);
      check("simul_overflow", 32'(overflow), 32'd0);
      check("simul_valid", 32'(rx.o_valid), 32'd1);
      check("simul_head_addr", 32'(rx.o_addr), 32'h22);
      rx.i_ready = 1'b1;
      wait_drain();
      check("simul_overflow_end", 32'(overflow), 32'd0);

      // Reset in the middle of a frame
      ferr_before = ferr_pulses;
      for (int i = 0; i < 12; i++) send_bit(1'($urandom), 1'b0);
      do_reset();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(rx.o_valid), 32'd0);
      check("midrst_addr", 32'(rx.o_addr), 32'd0);
      tick(5);
      deliver(8'h0A, 8'hC3);
      wait_drain();
      check("midrst_ferr", 32'(ferr_pulses), 32'(ferr_before));

      // rtck already high across reset release must not start a frame
      rtms = 1'b0; tdo = 1'b1;
      check("rtck_high_pre", 32'(rtck), 32'd1);
      do_reset();
      tick(10);
      check("no_spurious_edge", 32'(busy), 32'd0);
      deliver(8'h5C, 8'h3B);
      wait_drain();

      // Random traffic with a ready consumer
      for (int n = 0; n < 200; n++) begin
         logic [FRAME_BITS-1:0] f;
         f = FRAME_BITS'($urandom);
         model_frame(f);
         send_frame(f);
      end
      wait_drain();
      check("rand_overflow", 32'(overflow), 32'(exp_ovf));
      check("rand_ferr", 32'(ferr_pulses), 32'(ferr_before));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/scan_return_rx.md
SCAN_RETURN_RX -- requirements
Module: scan_return_rx

Interface
REQ-001 SHALL provide parameter NUM_IOS, default 8, data bits per frame.
REQ-002 SHALL provide parameter ADDR_BITS, default 8, address bits per frame.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth for rtck/rtms/tdo (minimum 2).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rtck  input  1  returned scan clock from the end of the tap chain, asynchronous to clk.
REQ-007 rtms  input  1  returned mode select; 0 = shift, 1 = idle/abort.
REQ-008 tdo  input  1  returned serial data, LSB first.
REQ-009 o_valid  output  1  frame available at FIFO head.
REQ-010 o_addr  output  ADDR_BITS  address field of head frame.
REQ-011 o_data  output  NUM_IOS  data field of head frame.
REQ-012 i_ready  input  1  consumer accepts head frame when o_valid & i_ready.
REQ-013 busy  output  1  high while a frame is being shifted in.
REQ-014 frame_err  output  1  one-cycle pulse on aborted frame.
REQ-015 overflow  output  1  sticky flag: completed frame dropped because FIFO full.
REQ-016 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-017 rtck, rtms, tdo SHALL each pass through SYNC_STAGES flops; all three use identical depth so they stay aligned.
REQ-018 A rtck rising edge SHALL be detected in cycle N when synchronized rtck is 1 and its one-cycle-delayed copy is 0; rtms/tdo sampled from the same synchronized stage.
REQ-019 FSM SHALL have states IDLE and SHIFT; bit counter width clog2(ADDR_BITS+NUM_IOS).
REQ-020 IDLE: on edge with rtms=0 -> shift tdo in as bit 0, cnt=1, go SHIFT; edge with rtms=1 -> stay IDLE, no error.
REQ-021 SHIFT: on edge with rtms=0 -> shift tdo into bit position cnt, cnt+1; no edge -> hold.
REQ-022 SHIFT: when the bit at position ADDR_BITS+NUM_IOS-1 is captured -> push frame {data,addr} (bits 0..ADDR_BITS-1 = addr), cnt=0, go IDLE.
REQ-023 SHIFT: edge with rtms=1 -> discard partial frame, pulse frame_err in cycle N+1, cnt=0, go IDLE.
REQ-024 busy SHALL equal (state==SHIFT).
REQ-025 Output buffer SHALL be a 2-entry FIFO; o_valid high whenever count>0; o_addr/o_data show head entry, stable while o_valid & !i_ready.
REQ-026 Push latency: frame completed by edge in cycle N SHALL appear with o_valid=1 in cycle N+1 when FIFO was empty.
REQ-027 Pop SHALL occur in any cycle with o_valid & i_ready; head advances next cycle.
REQ-028 Simultaneous push and pop with FIFO full SHALL accept both (count stays 2, no overflow).
REQ-029 Push with FIFO full and no pop SHALL drop the new frame, keep existing entries, set overflow in cycle N+1.
REQ-030 overflow SHALL stay set until clr_ovf or reset; clr_ovf coincident with a new overflow event leaves overflow set.
REQ-031 i_ready with o_valid=0 SHALL have no effect; FIFO pointers wrap modulo 2.

Reset
REQ-032 reset SHALL force: state IDLE, cnt 0, FIFO empty, o_valid 0, busy 0, frame_err 0, overflow 0, synchronizer and edge-detect flops 0.
REQ-033 o_addr/o_data SHALL read 0 after reset until first push.
REQ-034 reset asserted mid-frame SHALL discard the partial frame without frame_err pulse; first edge after reset release is treated as from IDLE.
REQ-035 A rtck already high at reset release SHALL not produce a spurious edge unless it first goes low.

Verification
REQ-036 rtms=0, shift 16 bits addr=0x01 data=0xA5 LSB first, i_ready=1 -> one o_valid pulse with o_addr=0x01, o_data=0xA5, frame_err=0, overflow=0.
REQ-037 i_ready=0, send frames 0x03/0x11, 0x04/0x22, 0x05/0x33 -> FIFO holds first two, overflow=1 after third; then i_ready=1 -> 0x11 then 0x22 popped in order; clr_ovf -> overflow=0.
REQ-038 rtms=1 on edge after 9 bits -> frame_err single-cycle pulse, busy drops, no o_valid; next full frame 0x07/0x5A received correctly.
REQ-039 FIFO full, final bit of new frame arrives in same cycle as pop -> count remains 2, overflow stays 0, new frame delivered third.
REQ-040 reset pulsed after 12 bits, then full frame 0x0A/0xC3 -> only 0x0A/0xC3 output, no frame_err.
REQ-041 rtck toggled at clk/4 with tdo changing on rtck falling edge, random data over 200 frames -> every frame matches scoreboard, no drops with i_ready=1.
